// File: rtl/lfsr_sweep_ctrl.sv
// lfsr_sweep_ctrl: seeds and steps an external LFSR, stopping on match, step limit, wrap-around or abort
module lfsr_sweep_ctrl #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] target,
  input  logic [CNT_W-1:0] max_steps,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_step,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             limit,
  output logic             wrap,
  output logic             aborted,
  output logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] match_value
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0]       state;
  logic [WIDTH-1:0] target_r;
  logic [CNT_W-1:0] max_r;
  logic             hit, lim, wr, stop;
  always_comb begin
    hit  = lfsr_q == target_r;
    lim  = steps == max_r;
    wr   = steps != '0 && lfsr_q == lfsr_seed;
    stop = abort || hit || lim || wr;
  end
  assign lfsr_load = state == LOAD;
  assign lfsr_step = state == RUN && !stop;
  assign busy      = state == LOAD || state == RUN;
  assign done      = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr_seed   <= '0;
      target_r    <= '0;
      max_r       <= '0;
      steps       <= '0;
      found       <= 1'b0;
      limit       <= 1'b0;
      wrap        <= 1'b0;
      aborted     <= 1'b0;
      match_value <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          lfsr_seed <= seed;
          target_r  <= target;
          max_r     <= max_steps;
          steps     <= '0;
          found     <= 1'b0;
          limit     <= 1'b0;
          wrap      <= 1'b0;
          aborted   <= 1'b0;
          state     <= LOAD;
        end
        LOAD: state <= RUN;
        RUN: if (stop) begin
          // priority: abort, match, limit, wrap
          aborted     <= abort;
          found       <= !abort && hit;
          limit       <= !abort && !hit && lim;
          wrap        <= !abort && !hit && !lim;
          match_value <= lfsr_q;
          state       <= DONE;
        end else steps <= steps + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_sweep_ctrl.sv
// tb_lfsr_sweep_ctrl: directed checks of lfsr_sweep_ctrl driving a 2-bit XNOR LFSR
module tb_lfsr_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0]  seed = '0, target = '0, lfsr_q;
  logic [15:0] max_steps = '0;
  logic        lfsr_load, lfsr_step, busy, done, found, limit, wrap, aborted;
  logic [1:0]  lfsr_seed, match_value;
  logic [15:0] steps;
  int          total = 0, passed = 0, n, nstep, ndone;

  lfsr_sweep_ctrl #(.WIDTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .target(target),
    .max_steps(max_steps), .lfsr_q(lfsr_q), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .lfsr_step(lfsr_step), .busy(busy), .done(done), .found(found), .limit(limit),
    .wrap(wrap), .aborted(aborted), .steps(steps), .match_value(match_value)
  );

  always #5 clk = ~clk;

  // external LFSR: 00->01->10->00, 11 locks
  always @(posedge clk)
    if (rst) lfsr_q <= 2'b00;
    else if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_step) lfsr_q <= {lfsr_q[0], ~(lfsr_q[1] ^ lfsr_q[0])};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // n counts cycles after the start-sampling edge; done is expected at n = steps + 3
  task automatic sweep(input logic [1:0] s, input logic [1:0] t, input logic [15:0] m,
                       input int abort_at, input int start_at);
    @(negedge clk);
    seed = s; target = t; max_steps = m; start = 1'b1;
    n = 0; nstep = 0;
    repeat (50) begin
      @(negedge clk);
      n++;
      start = (n == start_at);
      abort = (n == abort_at);
      if (n == 1) begin seed = ~s; target = ~t; max_steps = 16'd0; end
      #1;
      if (lfsr_step) nstep++;
      if (done) break;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic result(input string tag, input int exp_n, input int exp_nstep,
                        input logic [3:0] exp_flags, input logic [15:0] exp_steps,
                        input logic [1:0] exp_mv);
    chk({tag, "_latency"}, n, exp_n);
    chk({tag, "_nstep"}, nstep, exp_nstep);
    chk({tag, "_flags"}, {found, limit, wrap, aborted}, exp_flags);
    chk({tag, "_steps"}, steps, exp_steps);
    chk({tag, "_match"}, match_value, exp_mv);
    chk({tag, "_busy"}, busy, 1'b0);
    @(negedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_flags_held"}, {found, limit, wrap, aborted}, exp_flags);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {lfsr_load, lfsr_step, busy, done, found, limit, wrap, aborted}, 8'h00);
    chk("reset_regs", {steps, lfsr_seed, match_value}, 20'h0);
    rst = 1'b0;
    abort = 1'b1;
    @(negedge clk); #1;
    chk("abort_idle_ignored", {busy, done, aborted}, 3'b000);
    abort = 1'b0;

    sweep(2'b00, 2'b10, 16'd10, 0, 0);
    result("s1_found", 5, 2, 4'b1000, 16'd2, 2'b10);
    sweep(2'b00, 2'b11, 16'd10, 0, 0);
    result("s2_wrap", 6, 3, 4'b0010, 16'd3, 2'b00);
    sweep(2'b11, 2'b00, 16'd10, 0, 0);
    result("s3_lockup", 4, 1, 4'b0010, 16'd1, 2'b11);
    sweep(2'b00, 2'b10, 16'd1, 0, 0);
    result("s4_limit", 4, 1, 4'b0100, 16'd1, 2'b01);
    sweep(2'b00, 2'b11, 16'd100, 3, 0);
    result("s5_abort", 4, 1, 4'b0001, 16'd1, 2'b01);
    sweep(2'b01, 2'b01, 16'd10, 0, 0);
    result("tgt_eq_seed", 3, 0, 4'b1000, 16'd0, 2'b01);
    sweep(2'b00, 2'b11, 16'd0, 0, 0);
    result("max_zero", 3, 0, 4'b0100, 16'd0, 2'b00);

    @(negedge clk);
    seed = 2'b00; target = 2'b11; max_steps = 16'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("s6_rst_outs", {lfsr_load, lfsr_step, busy, done, found, limit, wrap, aborted}, 8'h00);
    chk("s6_rst_regs", {steps, lfsr_seed, match_value}, 20'h0);
    rst = 1'b0;
    ndone = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("s6_no_done_after_rst", ndone, 0);
    sweep(2'b00, 2'b10, 16'd10, 0, 3);
    result("s6_rerun", 5, 2, 4'b1000, 16'd2, 2'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
